// File: rtl/pipe_pkg.sv
// Shared payload types for the inter-stage registers.
// Every boundary uses an all-zero word as its NOP.
package pipe_pkg;

  localparam int STAGE_W = 160;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic        pred_taken;
  } ifid_payload_t;

  typedef struct packed {
    logic [31:0] pc_plus4;
    logic [3:0]  func;
    logic [1:0]  alu_a_sel;
    logic [1:0]  alu_b_sel;
    logic [1:0]  wb_sel;
    logic        mem_re;
    logic        mem_we;
    logic        reg_we;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] jmp_tgt;
    logic [31:0] br_tgt;
    logic [31:0] instr;
    logic        ld_byte;
    logic        ld_half;
    logic        ld_unsigned;
    logic        pred_taken;
  } idex_payload_t;

  typedef struct packed {
    logic [31:0] pc_plus4;
    logic [31:0] alu_res;
    logic [31:0] st_data;
    logic [4:0]  rd;
    logic        mem_re;
    logic        mem_we;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic        ld_byte;
    logic        ld_half;
    logic        ld_unsigned;
  } exmem_payload_t;

  typedef struct packed {
    logic [31:0] wb_data;
    logic [4:0]  rd;
    logic        reg_we;
  } memwb_payload_t;

  localparam int IFID_W  = $bits(ifid_payload_t);
  localparam int IDEX_W  = $bits(idex_payload_t);
  localparam int EXMEM_W = $bits(exmem_payload_t);
  localparam int MEMWB_W = $bits(memwb_payload_t);

  localparam ifid_payload_t  IFID_NOP  = '0;
  localparam idex_payload_t  IDEX_NOP  = '0;
  localparam exmem_payload_t EXMEM_NOP = '0;
  localparam memwb_payload_t MEMWB_NOP = '0;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready/data bundle for one pipeline boundary.
// master drives valid/data, slave drives ready.
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int WIDTH = STAGE_W
) ();

  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/pipe_sat_ctr.sv
// Saturating event counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module pipe_sat_ctr
  import pipe_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_q
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_q;

  // clear wins over increment; stop at all-ones
  always_ff @(posedge clock) begin
    if (!reset_n || i_clr) begin
      r_q <= '0;
    end else if (i_inc && (r_q != '1)) begin
      r_q <= r_q + ONE;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic stage register: single entry or two-entry skid.
// Optional stats counters under PIPE_STAGE_STATS_EN.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = STAGE_W,
  parameter int SKID  = 1,
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  pipe_stage_reg_if.slave  up,
  pipe_stage_reg_if.master dn,
  input  logic             bubble,
  input  logic             flush,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] stat_stall,
  output logic [CNT_W-1:0] stat_bubble,
  output logic [CNT_W-1:0] stat_flush
);

  logic             r_m_valid;
  logic [WIDTH-1:0] r_m_data;
  logic             r_s_valid;
  logic [WIDTH-1:0] r_s_data;

  logic w_in_ready;
  logic w_in_fire;
  logic w_out_fire;
  logic w_load_m;
  logic w_load_s;
  logic w_shift;

  // skid build decouples ready from out_ready
  always_comb begin
    w_in_ready = 1'b0;
    if (reset_n && !bubble && !flush) begin
      if (SKID != 0) begin
        w_in_ready = !r_s_valid;
      end else begin
        w_in_ready = !r_m_valid || dn.ready;
      end
    end
  end

  assign w_in_fire  = up.valid & w_in_ready;
  assign w_out_fire = r_m_valid & dn.ready;
  assign w_load_m   = w_in_fire & (!r_m_valid | w_out_fire);
  assign w_load_s   = w_in_fire & r_m_valid & !w_out_fire;
  assign w_shift    = w_out_fire & r_s_valid;

  assign up.ready = w_in_ready;
  assign dn.valid = r_m_valid;
  assign dn.data  = r_m_valid ? r_m_data : '0;

  // output entry: load, refill from skid, or drain
  always_ff @(posedge clock) begin
    if (!reset_n || flush) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
    end else if (w_load_m) begin
      r_m_valid <= 1'b1;
      r_m_data  <= up.data;
    end else if (w_shift) begin
      r_m_valid <= 1'b1;
      r_m_data  <= r_s_data;
    end else if (w_out_fire) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
    end
  end

  // skid entry: catches a beat while M is stalled
  always_ff @(posedge clock) begin
    if (!reset_n || flush) begin
      r_s_valid <= 1'b0;
      r_s_data  <= '0;
    end else if (w_load_s) begin
      r_s_valid <= 1'b1;
      r_s_data  <= up.data;
    end else if (w_shift) begin
      r_s_valid <= 1'b0;
      r_s_data  <= '0;
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  logic w_inc_stall;
  logic w_inc_bubble;
  logic w_inc_flush;

  assign w_inc_stall  = r_m_valid & !dn.ready;
  assign w_inc_bubble = bubble & up.valid;
  assign w_inc_flush  = flush &
                        ((r_m_valid & !w_out_fire) | r_s_valid);

  pipe_sat_ctr #(.CNT_W(CNT_W)) u_stall (
    .clock   (clock),
    .reset_n (reset_n),
    .i_clr   (stat_clr),
    .i_inc   (w_inc_stall),
    .o_q     (stat_stall)
  );

  pipe_sat_ctr #(.CNT_W(CNT_W)) u_bubble (
    .clock   (clock),
    .reset_n (reset_n),
    .i_clr   (stat_clr),
    .i_inc   (w_inc_bubble),
    .o_q     (stat_bubble)
  );

  pipe_sat_ctr #(.CNT_W(CNT_W)) u_flush (
    .clock   (clock),
    .reset_n (reset_n),
    .i_clr   (stat_clr),
    .i_inc   (w_inc_flush),
    .o_q     (stat_flush)
  );
`else
  logic w_unused_stat_clr;
  assign w_unused_stat_clr = stat_clr;
  assign stat_stall  = '0;
  assign stat_bubble = '0;
  assign stat_flush  = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=1 and SKID=0 side by side,
// table vectors, corner sequences, random vs queue model.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam int W   = 16;
  localparam int CW  = 4;
  localparam int MAX = (1 << CW) - 1;

  typedef struct {
    bit         iv;
    logic [W-1:0] d;
    bit         bub;
    bit         fl;
    bit         ordy;
    bit         e_ir;
    bit         e_ov;
    logic [W-1:0] e_od;
  } vec_t;

  logic clk;
  logic rst_n;
  logic iv, bub, fl, ordy, clr;
  logic [W-1:0] din;

  logic [CW-1:0] st_stall[2], st_bub[2], st_fl[2];

  pipe_stage_reg_if #(.WIDTH(W)) up0 ();
  pipe_stage_reg_if #(.WIDTH(W)) dn0 ();
  pipe_stage_reg_if #(.WIDTH(W)) up1 ();
  pipe_stage_reg_if #(.WIDTH(W)) dn1 ();

  assign up0.valid = iv;
  assign up0.data  = din;
  assign dn0.ready = ordy;
  assign up1.valid = iv;
  assign up1.data  = din;
  assign dn1.ready = ordy;

  pipe_stage_reg #(.WIDTH(W), .SKID(0), .CNT_W(CW)) u_dut0 (
    .clock       (clk),
    .reset_n     (rst_n),
    .up          (up0),
    .dn          (dn0),
    .bubble      (bub),
    .flush       (fl),
    .stat_clr    (clr),
    .stat_stall  (st_stall[0]),
    .stat_bubble (st_bub[0]),
    .stat_flush  (st_fl[0])
  );

  pipe_stage_reg #(.WIDTH(W), .SKID(1), .CNT_W(CW)) u_dut1 (
    .clock       (clk),
    .reset_n     (rst_n),
    .up          (up1),
    .dn          (dn1),
    .bubble      (bub),
    .flush       (fl),
    .stat_clr    (clr),
    .stat_stall  (st_stall[1]),
    .stat_bubble (st_bub[1]),
    .stat_flush  (st_fl[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] mq[2][$];
  int m_stall[2], m_bub[2], m_fl[2];

  vec_t tab[25];
  vec_t vz;

  function automatic vec_t mk(bit a, logic [W-1:0] d, bit b, bit f,
                              bit r, bit eir, bit eov,
                              logic [W-1:0] eod);
    vec_t v;
    v.iv = a; v.d = d; v.bub = b; v.fl = f; v.ordy = r;
    v.e_ir = eir; v.e_ov = eov; v.e_od = eod;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int sat(int v);
    return (v >= MAX) ? MAX : v + 1;
  endfunction

  // one clock: check against model, then advance model at edge
  task automatic step(input bit use_tab, input vec_t v);
    int  n[2];
    bit  e_ir[2], e_ov[2], fi[2], fo[2];
    logic [W-1:0] e_od[2];
    logic a_ir[2], a_ov[2];
    logic [W-1:0] a_od[2];
    #1;
    a_ir[0] = up0.ready; a_ov[0] = dn0.valid; a_od[0] = dn0.data;
    a_ir[1] = up1.ready; a_ov[1] = dn1.valid; a_od[1] = dn1.data;
    for (int k = 0; k < 2; k++) begin
      n[k]    = mq[k].size();
      e_ov[k] = n[k] > 0;
      e_od[k] = e_ov[k] ? mq[k][0] : '0;
      e_ir[k] = rst_n && !bub && !fl &&
                ((k == 1) ? (n[k] < 2) : (n[k] == 0 || ordy));
      fi[k]   = iv && e_ir[k];
      fo[k]   = e_ov[k] && ordy;
      chk($sformatf("in_ready[%0d]", k), 32'(a_ir[k]), 32'(e_ir[k]));
      chk($sformatf("out_valid[%0d]", k), 32'(a_ov[k]), 32'(e_ov[k]));
      chk($sformatf("out_data[%0d]", k), 32'(a_od[k]), 32'(e_od[k]));
      chk($sformatf("stat_stall[%0d]", k), 32'(st_stall[k]),
          32'(m_stall[k]));
      chk($sformatf("stat_bubble[%0d]", k), 32'(st_bub[k]),
          32'(m_bub[k]));
      chk($sformatf("stat_flush[%0d]", k), 32'(st_fl[k]),
          32'(m_fl[k]));
    end
    if (use_tab) begin
      chk("tab_in_ready", 32'(a_ir[1]), 32'(v.e_ir));
      chk("tab_out_valid", 32'(a_ov[1]), 32'(v.e_ov));
      chk("tab_out_data", 32'(a_od[1]), 32'(v.e_od));
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        mq[k].delete();
        m_stall[k] = 0; m_bub[k] = 0; m_fl[k] = 0;
      end else begin
        if (STATS) begin
          if (clr) begin
            m_stall[k] = 0; m_bub[k] = 0; m_fl[k] = 0;
          end else begin
            if (e_ov[k] && !ordy) m_stall[k] = sat(m_stall[k]);
            if (bub && iv) m_bub[k] = sat(m_bub[k]);
            if (fl && (n[k] - int'(fo[k])) >= 1)
              m_fl[k] = sat(m_fl[k]);
          end
        end
        if (fl) begin
          mq[k].delete();
        end else begin
          if (fo[k]) void'(mq[k].pop_front());
          if (fi[k]) mq[k].push_back(din);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(bit a, logic [W-1:0] d, bit b, bit f, bit r);
    iv = a; din = d; bub = b; fl = f; ordy = r;
  endtask

  initial begin
    vz = mk(0, '0, 0, 0, 0, 0, 0, '0);
    // streaming 1..8
    tab[0]  = mk(1, 16'h1, 0, 0, 1, 1, 0, 16'h0);
    for (int i = 1; i < 8; i++)
      tab[i] = mk(1, W'(i + 1), 0, 0, 1, 1, 1, W'(i));
    tab[8]  = mk(0, 16'h0, 0, 0, 1, 1, 1, 16'h8);
    // back-pressure A,B,C
    tab[9]  = mk(1, 16'hA, 0, 0, 0, 1, 0, 16'h0);
    tab[10] = mk(1, 16'hB, 0, 0, 0, 1, 1, 16'hA);
    tab[11] = mk(1, 16'hC, 0, 0, 0, 0, 1, 16'hA);
    tab[12] = mk(1, 16'hC, 0, 0, 1, 0, 1, 16'hA);
    tab[13] = mk(1, 16'hC, 0, 0, 1, 1, 1, 16'hB);
    tab[14] = mk(0, 16'h0, 0, 0, 1, 1, 1, 16'hC);
    // bubble
    tab[15] = mk(1, 16'hDEAD, 1, 0, 1, 0, 0, 16'h0);
    tab[16] = mk(1, 16'hDEAD, 0, 0, 1, 1, 0, 16'h0);
    tab[17] = mk(0, 16'h0, 0, 0, 1, 1, 1, 16'hDEAD);
    // flush with M=A1, S=B2, out_ready=1
    tab[18] = mk(1, 16'hA1, 0, 0, 0, 1, 0, 16'h0);
    tab[19] = mk(1, 16'hB2, 0, 0, 0, 1, 1, 16'hA1);
    tab[20] = mk(0, 16'h0, 0, 1, 1, 0, 1, 16'hA1);
    tab[21] = mk(0, 16'h0, 0, 0, 1, 1, 0, 16'h0);
    // flush together with bubble, M held
    tab[22] = mk(1, 16'h55, 0, 0, 0, 1, 0, 16'h0);
    tab[23] = mk(1, 16'h66, 1, 1, 0, 0, 1, 16'h55);
    tab[24] = mk(0, 16'h0, 0, 0, 1, 1, 0, 16'h0);

    for (int k = 0; k < 2; k++) begin
      m_stall[k] = 0; m_bub[k] = 0; m_fl[k] = 0;
    end

    rst_n = 1'b0; clr = 1'b0;
    drive(1, 16'h1234, 0, 0, 1);
    @(posedge clk);
    @(negedge clk);
    step(0, vz);
    step(0, vz);
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      drive(tab[i].iv, tab[i].d, tab[i].bub, tab[i].fl, tab[i].ordy);
      step(1, tab[i]);
    end

    // saturation: one beat held, 20 stall cycles
    drive(1, 16'h77, 0, 0, 0);
    step(0, vz);
    drive(0, 16'h0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, vz);
    #1;
    chk("sat_stall", 32'(st_stall[1]), STATS ? 32'(MAX) : 32'd0);
    clr = 1'b1;
    step(0, vz);
    clr = 1'b0;
    #1;
    chk("clr_stall", 32'(st_stall[1]), 32'd0);

    // reset mid-transfer
    drive(1, 16'h99, 0, 0, 0);
    step(0, vz);
    rst_n = 1'b0;
    step(0, vz);
    rst_n = 1'b1;
    drive(0, 16'h0, 0, 0, 0);
    #1;
    chk("rst_out_valid", 32'(dn1.valid), 32'd0);
    chk("rst_out_data", 32'(dn1.data), 32'd0);
    chk("rst_out_valid0", 32'(dn0.valid), 32'd0);
    step(0, vz);

    // random traffic against queue model
    for (int i = 0; i < 600; i++) begin
      drive(($urandom % 4) != 0, W'($urandom),
            ($urandom % 8) == 0, ($urandom % 16) == 0,
            ($urandom % 3) != 0);
      clr   = ($urandom % 32) == 0;
      rst_n = ($urandom % 64) != 0;
      step(0, vz);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
